// File: rtl/info_marker_encoder_if.sv
// rtl/info_marker_encoder_if.sv - request and commit-slot handshake bundle for the marker encoder
interface info_marker_encoder_if #(
    parameter int ID_W = 8
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_phase;
    logic            req_end;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [ID_W-1:0] out_id;

    modport master (
        output req_valid, req_phase, req_end, out_ready,
        input  req_ready, out_valid, out_inst, out_id
    );

    modport slave (
        input  req_valid, req_phase, req_end, out_ready,
        output req_ready, out_valid, out_inst, out_id
    );
endinterface

// File: rtl/info_marker_encoder.sv
// rtl/info_marker_encoder.sv - phase-event marker encoder with legality tracking and output FIFO
module info_marker_encoder #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    info_marker_encoder_if.slave  bus,
    output logic [6:0]            open_mask,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [15:0]           emit_count
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [1:0] VIOL_NONE  = 2'd0;
    localparam logic [1:0] VIOL_PHASE = 2'd1;
    localparam logic [1:0] VIOL_START = 2'd2;
    localparam logic [1:0] VIOL_END   = 2'd3;

    // Each entry stores only the 4-bit {phase, end} code; the fixed opcode bits are added on output.
    logic [3:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ID_W-1:0] id_q;

    logic            full;
    logic            empty;
    logic            accept;
    logic            push;
    logic            pop;
    logic            phase_open;
    logic [1:0]      viol;
    logic [7:0]      mask_ext;
    logic [7:0]      mask_upd;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign accept = bus.req_valid && !full;
    assign push   = accept && (viol == VIOL_NONE);
    assign pop    = !empty && bus.out_ready;

    // Phase 7 indexes the padding bit, which is always zero and never written back.
    assign mask_ext   = {1'b0, open_mask};
    assign phase_open = mask_ext[bus.req_phase];

    always_comb begin
        viol = VIOL_NONE;
        if (bus.req_phase == 3'd7) begin
            viol = VIOL_PHASE;
        end else if (!bus.req_end && phase_open) begin
            viol = VIOL_START;
        end else if (bus.req_end && !phase_open) begin
            viol = VIOL_END;
        end
    end

    always_comb begin
        mask_upd                = mask_ext;
        mask_upd[bus.req_phase] = !bus.req_end;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {bus.req_phase, bus.req_end};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            id_q       <= '0;
            open_mask  <= '0;
            err        <= 1'b0;
            err_code   <= VIOL_NONE;
            emit_count <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + (ADDR_W+1)'(1);
                open_mask <= mask_upd[6:0];
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
                id_q   <= id_q + ID_W'(1);
                if (emit_count != 16'hFFFF) begin
                    emit_count <= emit_count + 16'd1;
                end
            end
            if (accept && (viol != VIOL_NONE)) begin
                err <= 1'b1;
                if (!err) begin
                    err_code <= viol;
                end
            end
        end
    end

    assign bus.req_ready = !full;
    assign bus.out_valid = !empty;
    assign bus.out_id    = id_q;
    assign bus.out_inst  = empty ? 32'h0
                                 : {8'h00, mem[rd_ptr[ADDR_W-1:0]], 5'b0, 3'b010, 5'b0, 7'h13};
endmodule

// File: tb/tb_info_marker_encoder.sv
// tb/tb_info_marker_encoder.sv - self-checking bench for info_marker_encoder
module tb_info_marker_encoder;
    localparam int DEPTH = 4;
    localparam int ID_W  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  open_mask;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] emit_count;

    int tests_run    = 0;
    int tests_failed = 0;

    info_marker_encoder_if #(.ID_W(ID_W)) bus ();

    info_marker_encoder #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.slave),
        .open_mask  (open_mask),
        .err        (err),
        .err_code   (err_code),
        .emit_count (emit_count)
    );

    always #5 clock = ~clock;

    // Reference model: a queue of {phase,end} codes plus the externally visible bookkeeping.
    bit [3:0]  mq[$];
    bit [6:0]  m_mask;
    bit        m_err;
    bit [1:0]  m_code;
    bit [7:0]  m_id;
    bit [15:0] m_cnt;

    task automatic model_step();
        bit        ready;
        bit        popping;
        bit [1:0]  v;
        int        p;
        if (!reset) begin
            mq.delete();
            m_mask = '0; m_err = 0; m_code = 0; m_id = 0; m_cnt = 0;
            return;
        end
        ready   = (mq.size() < DEPTH);
        popping = (mq.size() > 0) && bus.out_ready;
        p       = int'(bus.req_phase);
        v       = 0;
        if (bus.req_valid && ready) begin
            if (p == 7) v = 1;
            else if (!bus.req_end && m_mask[p]) v = 2;
            else if (bus.req_end && !m_mask[p]) v = 3;
        end
        if (popping) begin
            void'(mq.pop_front());
            m_id = m_id + 8'd1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        if (bus.req_valid && ready) begin
            if (v == 0) begin
                mq.push_back({bus.req_phase, bus.req_end});
                m_mask[p] = !bus.req_end;
            end else begin
                if (!m_err) m_code = v;
                m_err = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic drive_req(input bit valid, input int phase, input bit is_end);
        bus.req_valid = valid;
        bus.req_phase = 3'(phase);
        bus.req_end   = is_end;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive_req(0, 0, 0);
        bus.out_ready = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({bus.out_valid, bus.req_ready, bus.out_inst, bus.out_id} !== {1'b0, 1'b1, 32'h0, 8'h0}) begin
            tests_failed++;
            $display("FAIL reset_out got v=%b r=%b inst=%h id=%h want v=0 r=1 inst=0 id=0",
                     bus.out_valid, bus.req_ready, bus.out_inst, bus.out_id);
        end
        tests_run++;
        if ({open_mask, err, err_code, emit_count} !== {7'h0, 1'b0, 2'd0, 16'h0}) begin
            tests_failed++;
            $display("FAIL reset_status got mask=%h err=%b code=%0d cnt=%0d want all zero",
                     open_mask, err, err_code, emit_count);
        end
    endtask

    task automatic test_basic();
        do_reset();
        bus.out_ready = 1'b1;
        drive_req(1, 0, 0);
        tick();
        tests_run++;
        if ({bus.out_valid, bus.out_inst, bus.out_id, open_mask} !== {1'b1, 32'h00002013, 8'd0, 7'h01}) begin
            tests_failed++;
            $display("FAIL basic_start got v=%b inst=%h id=%0d mask=%h want v=1 inst=00002013 id=0 mask=01",
                     bus.out_valid, bus.out_inst, bus.out_id, open_mask);
        end
        drive_req(1, 0, 1);
        tick();
        tests_run++;
        if ({bus.out_valid, bus.out_inst, bus.out_id, open_mask} !== {1'b1, 32'h00102013, 8'd1, 7'h00}) begin
            tests_failed++;
            $display("FAIL basic_end got v=%b inst=%h id=%0d mask=%h want v=1 inst=00102013 id=1 mask=00",
                     bus.out_valid, bus.out_inst, bus.out_id, open_mask);
        end
        drive_req(0, 0, 0);
        tick();
        tests_run++;
        if ({bus.out_valid, bus.out_inst, emit_count} !== {1'b0, 32'h0, 16'd2}) begin
            tests_failed++;
            $display("FAIL basic_drain got v=%b inst=%h cnt=%0d want v=0 inst=0 cnt=2",
                     bus.out_valid, bus.out_inst, emit_count);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int p = 0; p < 4; p++) begin
            drive_req(1, p, 0);
            tick();
        end
        drive_req(1, 4, 0);
        tests_run++;
        if ({bus.req_ready, bus.out_inst} !== {1'b0, 32'h00002013}) begin
            tests_failed++;
            $display("FAIL full_ready got r=%b inst=%h want r=0 inst=00002013", bus.req_ready, bus.out_inst);
        end
        bus.out_ready = 1'b1;
        tick();
        tests_run++;
        if ({bus.req_ready, bus.out_inst, bus.out_id} !== {1'b1, 32'h00202013, 8'd1}) begin
            tests_failed++;
            $display("FAIL full_nopass got r=%b inst=%h id=%0d want r=1 inst=00202013 id=1",
                     bus.req_ready, bus.out_inst, bus.out_id);
        end
        tick();
        drive_req(0, 0, 0);
        tests_run++;
        if (bus.out_inst !== 32'h00402013) begin
            tests_failed++;
            $display("FAIL full_order2 got %h want 00402013", bus.out_inst);
        end
        tick();
        tests_run++;
        if (bus.out_inst !== 32'h00602013) begin
            tests_failed++;
            $display("FAIL full_order3 got %h want 00602013", bus.out_inst);
        end
        tick();
        tests_run++;
        if ({bus.out_inst, open_mask} !== {32'h00802013, 7'h1F}) begin
            tests_failed++;
            $display("FAIL full_init got inst=%h mask=%h want inst=00802013 mask=1f", bus.out_inst, open_mask);
        end
        tick();
        tests_run++;
        if ({bus.out_valid, emit_count} !== {1'b0, 16'd5}) begin
            tests_failed++;
            $display("FAIL full_done got v=%b cnt=%0d want v=0 cnt=5", bus.out_valid, emit_count);
        end
    endtask

    task automatic test_errors();
        do_reset();
        drive_req(1, 3, 1);
        tick();
        drive_req(1, 7, 0);
        tick();
        drive_req(0, 0, 0);
        tests_run++;
        if ({bus.out_valid, err, err_code, open_mask} !== {1'b0, 1'b1, 2'd3, 7'h0}) begin
            tests_failed++;
            $display("FAIL err_first got v=%b err=%b code=%0d mask=%h want v=0 err=1 code=3 mask=00",
                     bus.out_valid, err, err_code, open_mask);
        end
        drive_req(1, 2, 0);
        tick();
        tick();
        drive_req(0, 0, 0);
        tests_run++;
        if ({bus.out_inst, open_mask, err_code} !== {32'h00402013, 7'h04, 2'd3}) begin
            tests_failed++;
            $display("FAIL err_reopen got inst=%h mask=%h code=%0d want inst=00402013 mask=04 code=3",
                     bus.out_inst, open_mask, err_code);
        end
        bus.out_ready = 1'b1;
        tick();
        tests_run++;
        if ({bus.out_valid, emit_count, err} !== {1'b0, 16'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL err_single got v=%b cnt=%0d err=%b want v=0 cnt=1 err=1",
                     bus.out_valid, emit_count, err);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive_req(1, 5, i[0]);
            tick();
        end
        drive_req(0, 0, 0);
        tests_run++;
        if ({bus.out_inst, bus.out_id} !== {32'h00b02013, 8'd255}) begin
            tests_failed++;
            $display("FAIL wrap_last got inst=%h id=%0d want inst=00b02013 id=255", bus.out_inst, bus.out_id);
        end
        tick();
        tests_run++;
        if ({bus.out_id, emit_count, bus.out_valid} !== {8'd0, 16'd256, 1'b0}) begin
            tests_failed++;
            $display("FAIL wrap_id got id=%0d cnt=%0d v=%b want id=0 cnt=256 v=0",
                     bus.out_id, emit_count, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b1;
        drive_req(1, 6, 0);
        tick();
        drive_req(0, 0, 0);
        tick();
        bus.out_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            drive_req(1, p, 0);
            tick();
        end
        reset = 1'b0;
        drive_req(1, 3, 0);
        tick();
        reset = 1'b1;
        drive_req(0, 0, 0);
        tests_run++;
        if ({bus.out_valid, open_mask, bus.out_id, emit_count, bus.out_inst} !==
            {1'b0, 7'h0, 8'd0, 16'd0, 32'h0}) begin
            tests_failed++;
            $display("FAIL midreset got v=%b mask=%h id=%0d cnt=%0d inst=%h want all zero",
                     bus.out_valid, open_mask, bus.out_id, emit_count, bus.out_inst);
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_noaccept got v=%b want v=0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_req(1, 0, 0);
        tick();
        drive_req(1, 1, 0);
        tick();
        drive_req(1, 2, 0);
        bus.out_ready = 1'b1;
        tick();
        tests_run++;
        if ({bus.out_inst, bus.out_id, bus.req_ready} !== {32'h00202013, 8'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL b2b_first got inst=%h id=%0d r=%b want inst=00202013 id=1 r=1",
                     bus.out_inst, bus.out_id, bus.req_ready);
        end
        drive_req(1, 0, 1);
        tick();
        tests_run++;
        if ({bus.out_inst, bus.out_id, open_mask} !== {32'h00402013, 8'd2, 7'h06}) begin
            tests_failed++;
            $display("FAIL b2b_second got inst=%h id=%0d mask=%h want inst=00402013 id=2 mask=06",
                     bus.out_inst, bus.out_id, open_mask);
        end
        drive_req(0, 0, 0);
        tick();
        tests_run++;
        if ({bus.out_inst, bus.out_id} !== {32'h00102013, 8'd3}) begin
            tests_failed++;
            $display("FAIL b2b_third got inst=%h id=%0d want inst=00102013 id=3", bus.out_inst, bus.out_id);
        end
        tick();
        tests_run++;
        if ({bus.out_valid, emit_count} !== {1'b0, 16'd4}) begin
            tests_failed++;
            $display("FAIL b2b_done got v=%b cnt=%0d want v=0 cnt=4", bus.out_valid, emit_count);
        end
    endtask

    task automatic test_random();
        int        p;
        bit [31:0] exp_inst;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            p = $urandom_range(0, 7);
            if ($urandom_range(0, 9) < 8) begin
                if (p == 7) p = $urandom_range(0, 6);
                drive_req($urandom_range(0, 2) != 0, p, m_mask[p]);
            end else begin
                drive_req($urandom_range(0, 2) != 0, p, 1'($urandom_range(0, 1)));
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 199) != 0);
            tick();
            exp_inst = (mq.size() > 0) ? (32'h00002013 | (32'(mq[0]) << 20)) : 32'h0;
            tests_run++;
            if ({bus.out_valid, bus.req_ready, bus.out_inst, bus.out_id, open_mask, err, err_code, emit_count} !==
                {mq.size() > 0, mq.size() < DEPTH, exp_inst, m_id, m_mask, m_err, m_code, m_cnt}) begin
                tests_failed++;
                $display("FAIL random cyc=%0d got v=%b r=%b inst=%h id=%0d mask=%h err=%b code=%0d cnt=%0d want v=%b r=%b inst=%h id=%0d mask=%h err=%b code=%0d cnt=%0d",
                         cyc, bus.out_valid, bus.req_ready, bus.out_inst, bus.out_id, open_mask, err, err_code,
                         emit_count, mq.size() > 0, mq.size() < DEPTH, exp_inst, m_id, m_mask, m_err, m_code, m_cnt);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        drive_req(0, 0, 0);
        bus.out_ready = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_full();
        test_errors();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
